calc_scoreboard: RTL and testbench

CALC_SCOREBOARD -- requirements
Module: calc_scoreboard

---
 rtl/calc_scoreboard.sv | 188 ++++++++++++++++++
 tb/tb_calc_scoreboard.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_scoreboard.sv
// -----------------------------------------------------------------------------
// calc_scoreboard
//   Per-port response checker for a multi-port calculator. Each port keeps a
//   small FIFO of expected {code, data} entries from the reference model.
//   Every DUV response pops the head entry and compares it against the DUV
//   output. Errors are flagged per port and counted globally.
//
// Ports
//   c_clk        sole clock, rising edge
//   reset        asynchronous active-low reset
//   cmp_en       comparison enable; low freezes all state
//   ref_resp     reference response code per port, port p at [2p+1:2p]
//   ref_data     reference output data per port, port p at [DATA_W*p +: DATA_W]
//   duv_resp     DUV response code per port, same packing as ref_resp
//   duv_data     DUV output data per port, same packing as ref_data
//   mismatch     sticky per-port compare failure (includes unexpected response)
//   overflow     sticky per-port FIFO overflow (reference entry dropped)
//   timeout      sticky per-port head-entry timeout
//   err_count    saturating total of all errors
//   match_count  saturating total of correct DUV responses
//   idle         high when every port FIFO is empty (combinational)
// -----------------------------------------------------------------------------
module calc_scoreboard #(
   parameter int N_PORTS = 4,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                      c_clk,
   input  logic                      reset,
   input  logic                      cmp_en,
   input  logic [2*N_PORTS-1:0]      ref_resp,
   input  logic [DATA_W*N_PORTS-1:0] ref_data,
   input  logic [2*N_PORTS-1:0]      duv_resp,
   input  logic [DATA_W*N_PORTS-1:0] duv_data,
   output logic [N_PORTS-1:0]        mismatch,
   output logic [N_PORTS-1:0]        overflow,
   output logic [N_PORTS-1:0]        timeout,
   output logic [15:0]               err_count,
   output logic [15:0]               match_count,
   output logic                      idle
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int ENT_W = DATA_W + 2;
   localparam int TMR_W = $clog2(TIMEOUT + 1);

   typedef enum logic {
      S_EMPTY,
      S_WAIT
   } port_state_t;

   logic [N_PORTS-1:0] port_empty;
   logic [N_PORTS-1:0] port_err;
   logic [N_PORTS-1:0] port_match;

   for (genvar p = 0; p < N_PORTS; p++) begin : g_port
      logic [ENT_W-1:0]  mem [DEPTH];
      logic [PTR_W:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
      logic [TMR_W-1:0]  timer;
      port_state_t       state;
      logic              mismatch_q, overflow_q, timeout_q;

      logic [1:0]        r_code, d_code;
      logic [DATA_W-1:0] r_data, d_data;
      logic              push, resp, empty, full;
      logic              bypass, unexpected, head_pop, expire, drop;
      logic              push_ok, rd_pop, code_ok, cmp_pass, cmp_fail;
      logic [ENT_W-1:0]  head, cand;

      assign r_code = ref_resp[2*p +: 2];
      assign d_code = duv_resp[2*p +: 2];
      assign r_data = ref_data[DATA_W*p +: DATA_W];
      assign d_data = duv_data[DATA_W*p +: DATA_W];

      // The extra pointer MSB tells full (MSBs differ) from empty (equal).
      assign empty = (wr_ptr == rd_ptr);
      assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

      assign push = cmp_en && (r_code != 2'd0);
      assign resp = cmp_en && (d_code != 2'd0);

      // Response on an empty FIFO either checks the same-cycle reference
      // entry directly (bypass) or is an unexpected response.
      assign bypass     = resp && empty && push;
      assign unexpected = resp && empty && !push;
      assign head_pop   = resp && !empty;

      // A pop in the same cycle resets the timer, so it pre-empts expiry.
      assign expire = cmp_en && (state == S_WAIT) && !resp &&
                      (timer == TMR_W'(TIMEOUT - 1));

      // A head pop or expiry frees a slot, so a push on full still fits.
      assign drop    = push && !bypass && full && !head_pop && !expire;
      assign push_ok = push && !bypass && !drop;
      assign rd_pop  = head_pop || expire;

      assign head    = mem[rd_ptr[PTR_W-1:0]];
      assign cand    = bypass ? {r_code, r_data} : head;
      // Data only carries meaning on a success code.
      assign code_ok = (cand[ENT_W-1 -: 2] == d_code) &&
                       ((d_code != 2'd1) || (cand[DATA_W-1:0] == d_data));
      assign cmp_pass = (bypass || head_pop) && code_ok;
      assign cmp_fail = (bypass || head_pop) && !code_ok;

      assign wr_ptr_nxt = wr_ptr + {{PTR_W{1'b0}}, push_ok};
      assign rd_ptr_nxt = rd_ptr + {{PTR_W{1'b0}}, rd_pop};

      // NOTE: FIFO storage has no reset; the pointers alone define validity.
      always_ff @(posedge c_clk) begin
         if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= {r_code, r_data};
      end

      // NOTE: sequential state uses non-blocking assignments only.
      always_ff @(posedge c_clk or negedge reset) begin
         if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            timer      <= '0;
            state      <= S_EMPTY;
            mismatch_q <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
         end else if (cmp_en) begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (cmp_fail || unexpected) mismatch_q <= 1'b1;
            if (drop)                   overflow_q <= 1'b1;
            if (expire)                 timeout_q  <= 1'b1;
            case (state)
               S_EMPTY: begin
                  timer <= '0;
                  if (push_ok) state <= S_WAIT;
               end
               S_WAIT: begin
                  if (wr_ptr_nxt == rd_ptr_nxt) begin
                     state <= S_EMPTY;
                     timer <= '0;
                  end else if (rd_pop) begin
                     timer <= '0;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               default: begin
                  state <= S_EMPTY;
                  timer <= '0;
               end
            endcase
         end
      end

      assign mismatch[p]   = mismatch_q;
      assign overflow[p]   = overflow_q;
      assign timeout[p]    = timeout_q;
      assign port_empty[p] = empty;
      assign port_err[p]   = cmp_fail || unexpected || drop || expire;
      assign port_match[p] = cmp_pass;
   end

   // Global counters: sum all per-port events of the cycle, then saturate
   // using the 17th bit as the carry-out.
   logic [16:0] err_nxt, match_nxt;

   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      err_nxt   = {1'b0, err_count};
      match_nxt = {1'b0, match_count};
      for (int i = 0; i < N_PORTS; i++) begin
         err_nxt   = err_nxt + {16'd0, port_err[i]};
         match_nxt = match_nxt + {16'd0, port_match[i]};
      end
   end

   always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
         err_count   <= '0;
         match_count <= '0;
      end else if (cmp_en) begin
         err_count   <= err_nxt[16] ? 16'hFFFF : err_nxt[15:0];
         match_count <= match_nxt[16] ? 16'hFFFF : match_nxt[15:0];
      end
   end

   assign idle = &port_empty;

endmodule

// File: tb/tb_calc_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_calc_scoreboard
//   Directed bench for calc_scoreboard with default parameters. Each stimulus
//   cycle pushes the expected output state onto a queue; after the clock edge
//   the head is popped and compared against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_calc_scoreboard;

   localparam int N_PORTS = 4;
   localparam int DATA_W  = 32;

   logic                      c_clk;
   logic                      reset;
   logic                      cmp_en;
   logic [2*N_PORTS-1:0]      ref_resp;
   logic [DATA_W*N_PORTS-1:0] ref_data;
   logic [2*N_PORTS-1:0]      duv_resp;
   logic [DATA_W*N_PORTS-1:0] duv_data;
   logic [N_PORTS-1:0]        mismatch;
   logic [N_PORTS-1:0]        overflow;
   logic [N_PORTS-1:0]        timeout;
   logic [15:0]               err_count;
   logic [15:0]               match_count;
   logic                      idle;

   calc_scoreboard dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .cmp_en      (cmp_en),
      .ref_resp    (ref_resp),
      .ref_data    (ref_data),
      .duv_resp    (duv_resp),
      .duv_data    (duv_data),
      .mismatch    (mismatch),
      .overflow    (overflow),
      .timeout     (timeout),
      .err_count   (err_count),
      .match_count (match_count),
      .idle        (idle)
   );

   initial begin
      c_clk = 1'b0;
      forever #5 c_clk = ~c_clk;
   end

   typedef struct {
      string       tag;
      logic [3:0]  mm;
      logic [3:0]  ov;
      logic [3:0]  to;
      logic [15:0] err;
      logic [15:0] match;
      logic        idle;
   } exp_t;

   exp_t exp_q[$];

   int vectors     = 0;
   int miscompares = 0;

   // Expected state, advanced by each scenario from its own knowledge.
   logic [3:0]  e_mm    = '0;
   logic [3:0]  e_ov    = '0;
   logic [3:0]  e_to    = '0;
   logic [15:0] e_err   = '0;
   logic [15:0] e_match = '0;
   logic        e_idle  = 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_now(input string tag);
      exp_t e;
      e.tag   = tag;
      e.mm    = e_mm;
      e.ov    = e_ov;
      e.to    = e_to;
      e.err   = e_err;
      e.match = e_match;
      e.idle  = e_idle;
      exp_q.push_back(e);
   endtask

   task automatic compare_head();
      exp_t e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard: got empty queue expected an entry");
         return;
      end
      e = exp_q.pop_front();
      check({e.tag, ".mismatch"},    32'(mismatch),    32'(e.mm));
      check({e.tag, ".overflow"},    32'(overflow),    32'(e.ov));
      check({e.tag, ".timeout"},     32'(timeout),     32'(e.to));
      check({e.tag, ".err_count"},   32'(err_count),   32'(e.err));
      check({e.tag, ".match_count"}, 32'(match_count), 32'(e.match));
      check({e.tag, ".idle"},        32'(idle),        32'(e.idle));
   endtask

   task automatic clear_inputs();
      ref_resp = '0;
      ref_data = '0;
      duv_resp = '0;
      duv_data = '0;
   endtask

   task automatic set_port(input int p, input logic [1:0] rc, input logic [31:0] rd,
                           input logic [1:0] dc, input logic [31:0] dd);
      ref_resp[2*p +: 2]           = rc;
      ref_data[DATA_W*p +: DATA_W] = rd;
      duv_resp[2*p +: 2]           = dc;
      duv_data[DATA_W*p +: DATA_W] = dd;
   endtask

   // Inputs are already set; record expectation, clock once, sample #1 later.
   task automatic step(input string tag);
      expect_now(tag);
      @(posedge c_clk);
      #1;
      clear_inputs();
      compare_head();
   endtask

   initial begin
      reset  = 1'b0;
      cmp_en = 1'b1;
      clear_inputs();
      #3;
      expect_now("reset");
      compare_head();
      @(posedge c_clk);
      #1;
      reset = 1'b1;

      // Single matched pair on port 1, response three cycles after push.
      set_port(1, 2'd1, 32'h5, 2'd0, 32'h0);
      e_idle = 1'b0;
      step("p1_push");
      step("p1_wait1");
      step("p1_wait2");
      set_port(1, 2'd0, 32'h0, 2'd1, 32'h5);
      e_match = 16'd1;
      e_idle  = 1'b1;
      step("p1_match");

      // Port 2: data mismatch on success, then code-only compare on code 2.
      set_port(2, 2'd1, 32'h10, 2'd0, 32'h0);
      e_idle = 1'b0;
      step("p2_push_a");
      set_port(2, 2'd0, 32'h0, 2'd1, 32'h11);
      e_mm   = 4'b0100;
      e_err  = 16'd1;
      e_idle = 1'b1;
      step("p2_bad_data");
      set_port(2, 2'd2, 32'h5, 2'd0, 32'h0);
      e_idle = 1'b0;
      step("p2_push_b");
      set_port(2, 2'd0, 32'h0, 2'd2, 32'h9);
      e_match = 16'd2;
      e_idle  = 1'b1;
      step("p2_code2");
      // Bypass: push and response together on an empty FIFO.
      set_port(2, 2'd3, 32'h1, 2'd3, 32'h2);
      e_match = 16'd3;
      step("p2_bypass");

      // Port 0 overflow: fifth push is dropped, first four retained in order.
      for (int i = 0; i < 4; i++) begin
         set_port(0, 2'd1, 32'hA0 + 32'(i), 2'd0, 32'h0);
         e_idle = 1'b0;
         step("p0_fill");
      end
      set_port(0, 2'd1, 32'hA4, 2'd0, 32'h0);
      e_ov  = 4'b0001;
      e_err = 16'd2;
      step("p0_overflow");
      for (int i = 0; i < 4; i++) begin
         set_port(0, 2'd0, 32'h0, 2'd1, 32'hA0 + 32'(i));
         e_match = e_match + 16'd1;
         if (i == 3) e_idle = 1'b1;
         step("p0_drain");
      end

      // Push and pop together on a full FIFO: both succeed, no error.
      for (int i = 0; i < 4; i++) begin
         set_port(0, 2'd1, 32'hB0 + 32'(i), 2'd0, 32'h0);
         e_idle = 1'b0;
         step("p0_refill");
      end
      set_port(0, 2'd1, 32'hB4, 2'd1, 32'hB0);
      e_match = e_match + 16'd1;
      step("p0_full_pushpop");
      for (int i = 1; i < 5; i++) begin
         set_port(0, 2'd0, 32'h0, 2'd1, 32'hB0 + 32'(i));
         e_match = e_match + 16'd1;
         if (i == 4) e_idle = 1'b1;
         step("p0_drain2");
      end

      // Port 3 timeout: head discarded on the 64th cycle after the push.
      set_port(3, 2'd1, 32'h33, 2'd0, 32'h0);
      e_idle = 1'b0;
      step("p3_push");
      for (int i = 0; i < 63; i++) step("p3_waiting");
      e_to   = 4'b1000;
      e_err  = 16'd3;
      e_idle = 1'b1;
      step("p3_timeout");

      // cmp_en low freezes everything: no timeout, no push, no error.
      set_port(1, 2'd1, 32'hAA, 2'd0, 32'h0);
      e_idle = 1'b0;
      step("freeze_push");
      cmp_en = 1'b0;
      for (int i = 0; i < 80; i++) begin
         set_port(0, 2'd0, 32'h0, 2'd1, 32'h1);
         set_port(1, 2'd1, 32'hBB, 2'd0, 32'h0);
         step("frozen");
      end
      cmp_en = 1'b1;
      set_port(1, 2'd0, 32'h0, 2'd1, 32'hAA);
      e_match = e_match + 16'd1;
      e_idle  = 1'b1;
      step("thaw_match");

      // Reset mid-stream with three entries pending on port 2.
      for (int i = 0; i < 3; i++) begin
         set_port(2, 2'd1, 32'hC0 + 32'(i), 2'd0, 32'h0);
         e_idle = 1'b0;
         step("pre_reset_push");
      end
      reset = 1'b0;
      #2;
      e_mm = '0; e_ov = '0; e_to = '0; e_err = '0; e_match = '0; e_idle = 1'b1;
      expect_now("async_reset");
      compare_head();
      @(posedge c_clk);
      #1;
      expect_now("reset_held");
      compare_head();
      reset = 1'b1;
      set_port(2, 2'd1, 32'h77, 2'd0, 32'h0);
      e_idle = 1'b0;
      step("post_reset_push");
      set_port(2, 2'd0, 32'h0, 2'd1, 32'h77);
      e_match = 16'd1;
      e_idle  = 1'b1;
      step("post_reset_match");

      // Unexpected responses on all ports every cycle until err_count saturates.
      for (int k = 0; k < 16390; k++) begin
         for (int p = 0; p < N_PORTS; p++) set_port(p, 2'd0, 32'h0, 2'd3, 32'h0);
         e_mm  = 4'b1111;
         e_err = (int'(e_err) + 4 > 65535) ? 16'hFFFF : e_err + 16'd4;
         step("saturate");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
